// File: rtl/note_chart_player.sv
`default_nettype none
// ============================================================================
// Module   : note_chart_player
// Purpose  : Plays a writable beat chart into five falling-note lanes, one
//            scroll step per frame tick. Define CHART_LOOP_EN to loop the chart.
// Revision : 1.0 - initial release
// ============================================================================
module note_chart_player #(
  parameter int CHART_DEPTH = 64,
  parameter int START_Y     = 0,
  parameter int END_Y       = 479,
  parameter int SPEED       = 2,
  parameter int BEAT_FRAMES = 15
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       chart_wr_en,
  input  logic [5:0] chart_wr_addr,
  input  logic [5:0] chart_wr_data,
  output logic [9:0] green_y_pos,
  output logic [9:0] red_y_pos,
  output logic [9:0] yellow_y_pos,
  output logic [9:0] blue_y_pos,
  output logic [9:0] orange_y_pos,
  output logic       playing,
  output logic       song_done,
  output logic [5:0] row_idx,
  output logic [7:0] collisions
);

  localparam int         c_beat_w     = (BEAT_FRAMES > 1) ? $clog2(BEAT_FRAMES) : 1;
  localparam logic [9:0] c_inactive_y = 10'h3FF;
  localparam logic [5:0] c_last_row   = 6'(CHART_DEPTH - 1);
`ifdef CHART_LOOP_EN
  localparam bit         c_loop_en    = 1'b1;
`else
  localparam bit         c_loop_en    = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_frame_d;
  logic [5:0]            r_chart [CHART_DEPTH];
  logic [5:0]            r_row_data;
  logic [5:0]            r_row_idx;
  logic [c_beat_w-1:0]   r_beat_cnt;
  logic [7:0]            r_coll;
  logic [4:0]            r_act;
  logic [9:0]            r_y [5];
  logic                  r_playing;
  logic                  r_song_done;

  logic                  w_idle_like;
  logic                  w_tick;
  logic                  w_beat;
  logic                  w_end;
  logic [4:0]            w_adv_act;
  logic [4:0]            w_spawn;
  logic [4:0]            w_drop;
  logic [4:0]            w_next_act;
  logic [9:0]            w_next_y [5];
  logic [2:0]            w_drop_cnt;
  logic [8:0]            w_coll_sum;
  logic [7:0]            w_coll_next;
  logic [5:0]            w_row_next;

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_tick      = frame_clk && !r_frame_d && !pause &&
                       ((r_state == S_PLAY) || (r_state == S_DRAIN));
  assign w_beat      = w_tick && (r_state == S_PLAY) &&
                       (r_beat_cnt == c_beat_w'(BEAT_FRAMES - 1));
  assign w_end       = w_beat && (r_row_data[5] || (r_row_idx == c_last_row));
  assign w_row_next  = (w_end && c_loop_en) ? 6'd0 : (r_row_idx + 6'd1);

  // Spawns and drops are decided against lane activity after this tick's advance.
  for (genvar gi = 0; gi < 5; gi++) begin : g_lane
    logic [10:0] w_sum;
    assign w_sum          = {1'b0, r_y[gi]} + 11'(SPEED);
    assign w_adv_act[gi]  = r_act[gi] && (w_sum <= 11'(END_Y));
    assign w_spawn[gi]    = w_beat && r_row_data[gi] && !w_adv_act[gi];
    assign w_drop[gi]     = w_beat && r_row_data[gi] &&  w_adv_act[gi];
    assign w_next_act[gi] = w_spawn[gi] || w_adv_act[gi];
    assign w_next_y[gi]   = w_spawn[gi]   ? 10'(START_Y) :
                            w_adv_act[gi] ? w_sum[9:0]   : c_inactive_y;
  end

  always_comb begin
    w_drop_cnt = 3'd0;
    for (int i = 0; i < 5; i++) begin
      w_drop_cnt = w_drop_cnt + 3'(w_drop[i]);
    end
  end

  assign w_coll_sum  = {1'b0, r_coll} + {6'd0, w_drop_cnt};
  assign w_coll_next = w_coll_sum[8] ? 8'hFF : w_coll_sum[7:0];

  always_comb begin
    w_next_state = r_state;
    if (stop) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start) w_next_state = S_PLAY;
        S_PLAY:         if (w_end && !c_loop_en) w_next_state = S_DRAIN;
        S_DRAIN:        if (r_act == 5'd0) w_next_state = S_DONE;
        default:        w_next_state = S_IDLE;
      endcase
    end
  end

  // Chart RAM: synchronous read, continuously addressed by the row pointer.
  always_ff @(posedge Clk) begin
    if (chart_wr_en && w_idle_like) begin
      r_chart[chart_wr_addr] <= chart_wr_data;
    end
    r_row_data <= r_chart[r_row_idx];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= S_IDLE;
      r_frame_d   <= 1'b0;
      r_row_idx   <= 6'd0;
      r_beat_cnt  <= '0;
      r_coll      <= 8'd0;
      r_act       <= 5'd0;
      r_playing   <= 1'b0;
      r_song_done <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        r_y[i] <= c_inactive_y;
      end
    end else begin
      r_frame_d   <= frame_clk;
      r_state     <= w_next_state;
      r_playing   <= (w_next_state == S_PLAY) || (w_next_state == S_DRAIN);
      r_song_done <= (w_next_state == S_DONE);
      if (stop) begin
        r_row_idx  <= 6'd0;
        r_beat_cnt <= '0;
        r_act      <= 5'd0;
        for (int i = 0; i < 5; i++) begin
          r_y[i] <= c_inactive_y;
        end
      end else if (w_idle_like && start) begin
        r_row_idx  <= 6'd0;
        r_beat_cnt <= '0;
        r_coll     <= 8'd0;
      end else if (w_tick) begin
        r_act <= w_next_act;
        for (int i = 0; i < 5; i++) begin
          r_y[i] <= w_next_y[i];
        end
        if (r_state == S_PLAY) begin
          if (w_beat) begin
            r_beat_cnt <= '0;
            r_coll     <= w_coll_next;
            r_row_idx  <= w_row_next;
          end else begin
            r_beat_cnt <= r_beat_cnt + c_beat_w'(1);
          end
        end
      end
    end
  end

  assign green_y_pos  = r_y[0];
  assign red_y_pos    = r_y[1];
  assign yellow_y_pos = r_y[2];
  assign blue_y_pos   = r_y[3];
  assign orange_y_pos = r_y[4];
  assign playing      = r_playing;
  assign song_done    = r_song_done;
  assign row_idx      = r_row_idx;
  assign collisions   = r_coll;

endmodule
`default_nettype wire

// File: tb/tb_note_chart_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_chart_player
// Purpose  : Scoreboard bench for note_chart_player against a lane-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_chart_player;

  localparam int P_START = 0;
  localparam int P_END   = 479;
  localparam int P_SPEED = 2;
  localparam int P_BEAT  = 15;
`ifdef CHART_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  localparam int M_IDLE = 0, M_PLAY = 1, M_DRAIN = 2, M_DONE = 3;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic       chart_wr_en = 1'b0;
  logic [5:0] chart_wr_addr = 6'd0, chart_wr_data = 6'd0;
  logic [9:0] green_y_pos, red_y_pos, yellow_y_pos, blue_y_pos, orange_y_pos;
  logic       playing, song_done;
  logic [5:0] row_idx;
  logic [7:0] collisions;

  note_chart_player #(
    .CHART_DEPTH(64), .START_Y(P_START), .END_Y(P_END),
    .SPEED(P_SPEED), .BEAT_FRAMES(P_BEAT)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .start(start),
    .stop(stop), .pause(pause), .chart_wr_en(chart_wr_en),
    .chart_wr_addr(chart_wr_addr), .chart_wr_data(chart_wr_data),
    .green_y_pos(green_y_pos), .red_y_pos(red_y_pos),
    .yellow_y_pos(yellow_y_pos), .blue_y_pos(blue_y_pos),
    .orange_y_pos(orange_y_pos), .playing(playing), .song_done(song_done),
    .row_idx(row_idx), .collisions(collisions)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] when;
    logic [49:0] ys;
    logic [5:0]  row;
    logic [7:0]  coll;
    logic        play;
    logic        done;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: each lane is a y value, -1 when empty.
  int         m_y [5];
  int         m_state, m_row, m_beat, m_coll;
  logic [5:0] m_chart [64];

  function automatic exp_t snap(input int when);
    exp_t e;
    e.when = 32'(when);
    for (int i = 0; i < 5; i++) e.ys[i*10 +: 10] = (m_y[i] < 0) ? 10'h3FF : 10'(m_y[i]);
    e.row  = 6'(m_row);
    e.coll = 8'(m_coll);
    e.play = (m_state == M_PLAY) || (m_state == M_DRAIN);
    e.done = (m_state == M_DONE);
    return e;
  endfunction

  function automatic void m_clear_lanes();
    for (int i = 0; i < 5; i++) m_y[i] = -1;
  endfunction

  function automatic void m_tick();
    logic [5:0] bits;
    bit last;
    if (m_state != M_PLAY && m_state != M_DRAIN) return;
    for (int i = 0; i < 5; i++)
      if (m_y[i] >= 0) m_y[i] = (m_y[i] + P_SPEED > P_END) ? -1 : m_y[i] + P_SPEED;
    if (m_state != M_PLAY) return;
    if (m_beat != P_BEAT - 1) begin
      m_beat++;
      return;
    end
    m_beat = 0;
    bits = m_chart[m_row];
    for (int i = 0; i < 5; i++)
      if (bits[i]) begin
        if (m_y[i] < 0) m_y[i] = P_START;
        else if (m_coll < 255) m_coll++;
      end
    last = bits[5] || (m_row == 63);
    if (LOOP && last) m_row = 0;
    else m_row = (m_row + 1) % 64;
    if (!LOOP && last) m_state = M_DRAIN;
  endfunction

  // DRAIN->DONE lands one clock after the retiring tick; the model is ahead.
  function automatic void m_settle();
    bit any;
    any = 1'b0;
    for (int i = 0; i < 5; i++) if (m_y[i] >= 0) any = 1'b1;
    if (m_state == M_DRAIN && !any) m_state = M_DONE;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
    end
  endtask

  // Monitor: compares every scoreboard entry whose time has come.
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge Clk);
      while (exp_q.size() > 0 && exp_q[0].when <= 32'(cyc)) begin
        mon_e = exp_q.pop_front();
        chk("lanes", 64'({orange_y_pos, blue_y_pos, yellow_y_pos, red_y_pos, green_y_pos}), 64'(mon_e.ys));
        chk("row_idx", 64'(row_idx), 64'(mon_e.row));
        chk("collisions", 64'(collisions), 64'(mon_e.coll));
        chk("flags", 64'({playing, song_done}), 64'({mon_e.play, mon_e.done}));
      end
    end
  end

  task automatic wr(input int a, input logic [5:0] d);
    @(negedge Clk);
    chart_wr_en = 1'b1; chart_wr_addr = 6'(a); chart_wr_data = d;
    if (m_state == M_IDLE || m_state == M_DONE) m_chart[a] = d;
    @(negedge Clk);
    chart_wr_en = 1'b0;
  endtask

  task automatic frame(input int hi, input int lo, input bit p);
    @(negedge Clk);
    frame_clk = 1'b1; pause = p;
    if (!p) m_tick();
    exp_q.push_back(snap(cyc + 1));
    m_settle();
    repeat (hi - 1) @(negedge Clk);
    @(negedge Clk);
    frame_clk = 1'b0; pause = 1'b0;
    repeat (lo - 1) @(negedge Clk);
  endtask

  task automatic do_start();
    @(negedge Clk);
    start = 1'b1;
    if (m_state == M_IDLE || m_state == M_DONE) begin
      m_state = M_PLAY; m_row = 0; m_beat = 0; m_coll = 0;
    end
    exp_q.push_back(snap(cyc + 1));
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic do_stop(input bit with_tick);
    @(negedge Clk);
    stop = 1'b1; frame_clk = with_tick;
    m_state = M_IDLE; m_row = 0; m_beat = 0;
    m_clear_lanes();
    exp_q.push_back(snap(cyc + 1));
    @(negedge Clk);
    stop = 1'b0; frame_clk = 1'b0;
  endtask

  // Reset is asserted between clock edges and checked before the next one.
  task automatic do_reset();
    @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    m_state = M_IDLE; m_row = 0; m_beat = 0; m_coll = 0;
    m_clear_lanes();
    exp_q.push_back(snap(cyc));
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int endrow, limit;
    logic [5:0] d;
    m_clear_lanes();
    m_state = M_IDLE; m_row = 0; m_beat = 0; m_coll = 0;
    for (int i = 0; i < 64; i++) m_chart[i] = 6'd0;
    repeat (3) @(negedge Clk);
    do_reset();

    // Single green note, end marker on row 1, with pause and a long frame pulse.
    wr(0, 6'h01);
    wr(1, 6'h20);
    do_start();
    for (int t = 1; t <= 262; t++) begin
      if (t == 20) for (int k = 0; k < 10; k++) frame(1, 2, 1'b1);
      if (t == 17) wr(1, 6'h01);
      if (t == 40) frame(100, 2, 1'b0);
      else frame($urandom_range(1, 3), $urandom_range(1, 3), 1'b0);
    end

    // Collision: green still falling when row 1 re-requests it.
    wr(0, 6'h1F);
    wr(1, 6'h01);
    wr(2, 6'h20);
    do_start();
    for (int t = 0; t < 33; t++) frame(1, 1, 1'b0);
    do_stop(1'b1);
    wr(0, 6'h02);
    do_start();
    for (int t = 0; t < 17; t++) frame(2, 1, 1'b0);
    do_reset();

    // Randomized songs.
    for (int s = 0; s < 3; s++) begin
      endrow = $urandom_range(3, 9);
      for (int r = 0; r < 64; r++) begin
        d = 6'($urandom_range(0, 31) & $urandom_range(0, 31));
        if (r == endrow) d[5] = 1'b1;
        wr(r, d);
      end
      do_start();
      limit = LOOP ? 200 : 450;
      for (int t = 0; t < limit && m_state != M_DONE; t++)
        frame($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(0, 7) == 0);
      if (!LOOP) chk("random_song_done", 64'(m_state == M_DONE), 64'd1);
      do_stop(1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge Clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/note_chart_player.md
# note_chart_player

Generates the five falling-note lane positions consumed by the score logic and the note sprite renderer. Plays a small writable chart (one lane bitmap per beat row), spawns notes at the top of the playfield, scrolls them once per video frame, and retires them past the bottom. It sits between the keyboard/host setup path, which loads the chart, and the scoring and drawing blocks, which read the `*_y_pos` outputs.

## Interface
- `CHART_DEPTH`, 64: number of chart rows; address width is 6.
- `START_Y`, 0: y of a newly spawned note.
- `END_Y`, 479: last visible y; a note whose next y would exceed it retires.
- `SPEED`, 2: pixels advanced per frame tick.
- `BEAT_FRAMES`, 15: frame ticks between chart rows; must be at least 1.
- `Clk` in 1: system clock, 50 MHz.
- `Reset_n` in 1: asynchronous, active-low reset.
- `frame_clk` in 1: vsync-rate strobe; its rising edge is one frame tick.
- `start` in 1: level; sampled in IDLE or DONE to begin playback from row 0.
- `stop` in 1: level; forces IDLE from any state and clears all lanes.
- `pause` in 1: while high, frame ticks are ignored.
- `chart_wr_en` in 1: chart write strobe; honoured only in IDLE or DONE.
- `chart_wr_addr` in 6: chart row address.
- `chart_wr_data` in 6: bits [4:0] hold the lane bitmap (bit0 green, bit1 red, bit2 yellow, bit3 blue, bit4 orange); bit5 is the end-of-chart marker.
- `green_y_pos`, `red_y_pos`, `yellow_y_pos`, `blue_y_pos`, `orange_y_pos` out 10: lane note y; 10'h3FF when the lane is inactive.
- `playing` out 1: high in PLAY or DRAIN.
- `song_done` out 1: high in DONE.
- `row_idx` out 6: next chart row to be fetched.
- `collisions` out 8: saturating count of dropped spawns.

## Operation
- Reset: every lane outputs 10'h3FF and is inactive; state IDLE; `row_idx`=0; beat counter 0; `collisions`=0; `playing`=0; `song_done`=0. Chart memory is not cleared.
- FSM IDLE -> PLAY on `start`; PLAY -> DRAIN on an end-marker fetch or after row CHART_DEPTH-1 is processed; DRAIN -> DONE when all lanes are inactive; DONE -> PLAY on `start`. `stop` forces IDLE from any state, clears the lanes, resets `row_idx` and the beat counter, and leaves `collisions` unchanged.
- Entering PLAY zeroes `row_idx`, the beat counter and `collisions`.
- Frame tick in PLAY or DRAIN with `pause` low:
  - Step 1, advance. Each active lane computes y+SPEED in 11 bits. If the result is greater than END_Y, the lane retires (inactive, output 3FF); otherwise y is updated to the result.
  - Step 2, PLAY only. The beat counter increments. When it equals BEAT_FRAMES-1 it wraps to 0 and row `row_idx` is applied:
    - A set bit on a lane that is inactive after step 1 spawns a note at START_Y.
    - A set bit on a still-active lane is dropped and increments `collisions`, saturating at 255.
    - `row_idx` then increments.
    - Multiple drops in one row add their total count.
  - A row with bit5 set spawns its bitmap normally and then moves to DRAIN.
- Ticks in IDLE or DONE, or with `pause` high, change nothing.
- Chart writes outside IDLE or DONE are ignored.

## Timing
- The frame edge is detected with one register. All lane, counter and FSM updates land on the Clk edge after `frame_clk` is first sampled high, following a low sample. Exactly one update happens per rising edge, regardless of pulse width.
- Chart read is synchronous and continuously addressed by `row_idx`, so data is valid at least one cycle before any beat.
- `start`, `stop` and writes take effect on the next Clk edge. `stop` takes priority over a coincident tick. A tick coincident with `start` is ignored.
- The first row spawns on the BEAT_FRAMES-th tick after `start`.
- Outputs are registered and never glitch mid-frame.

## Configuration
- `CHART_LOOP_EN` defined: an end marker, or reaching row CHART_DEPTH-1, wraps `row_idx` to 0 and stays in PLAY. DRAIN and DONE are never entered; only `stop` or reset ends playback.
- `CHART_LOOP_EN` undefined: end-of-chart goes through DRAIN to DONE as described above.

## Test plan
- Reset, then load row0=6'h01 and row1=6'h20. Start with BEAT_FRAMES=15 and SPEED=2. Required: green_y_pos=0 after tick 15, 2 after tick 16; `song_done` rises once green retires at the tick where y would exceed 479; the other lanes stay at 3FF throughout.
- Row0=6'h1F and row1=6'h01 with BEAT_FRAMES=1. Required: green is still active when row1 applies, so `collisions`=1 and the spawn is dropped.
- Set `pause` high for 10 ticks mid-song. Required: positions, `row_idx` and the beat counter are unchanged; scrolling resumes exactly one step after `pause` falls.
- Assert `stop` on the same cycle a tick is detected. Required: all lanes read 3FF, state IDLE, `row_idx`=0; a chart write in the next cycle succeeds.
- Hold `frame_clk` high for 100 Clk cycles. Required: exactly one advance. Deassert `Reset_n` mid-song. Required: all outputs return to reset values immediately, without waiting for a Clk edge.
- With `CHART_LOOP_EN` defined and a 2-row chart whose row1 has the end marker. Required: `row_idx` goes 0,1,0,1 and `song_done` stays 0.
